// File: rtl/exu_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle EXU sequencer.
// Instruction numbers mirror the IDU encoding.
package exu_seq_ctrl_pkg;

  localparam int INST_NUM_WIDTH = 6;
  localparam int ISA_WIDTH = 32;
  localparam int PC_SEL_WIDTH = 2;
  localparam int SEQ_STATE_WIDTH = 4;

  localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI = 6'd1;
  localparam logic [INST_NUM_WIDTH-1:0] INST_LW = 6'd2;
  localparam logic [INST_NUM_WIDTH-1:0] INST_SW = 6'd3;
  localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ = 6'd4;
  localparam logic [INST_NUM_WIDTH-1:0] INST_BNE = 6'd5;
  localparam logic [INST_NUM_WIDTH-1:0] INST_JAL = 6'd6;
  localparam logic [INST_NUM_WIDTH-1:0] INST_JALR = 6'd7;
  localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 6'd8;

  localparam logic [PC_SEL_WIDTH-1:0] PC_SNPC = 2'd0;
  localparam logic [PC_SEL_WIDTH-1:0] PC_IMM = 2'd1;
  localparam logic [PC_SEL_WIDTH-1:0] PC_JALR = 2'd2;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_IDLE   = 4'd0,
    SEQ_FETCH  = 4'd1,
    SEQ_DECODE = 4'd2,
    SEQ_EXEC   = 4'd3,
    SEQ_MEM_RD = 4'd4,
    SEQ_MEM_WR = 4'd5,
    SEQ_WB     = 4'd6,
    SEQ_HALT   = 4'd7,
    SEQ_ERR    = 4'd8
  } seq_state_t;

  function automatic logic is_branch(
    input logic [INST_NUM_WIDTH-1:0] n
  );
    return (n == INST_BEQ) || (n == INST_BNE);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Bus wait watchdog shared by fetch and data-memory waits.
// expired is high once TIMEOUT-1 cycles passed without an ack.
module seq_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, MEM, WB.
// Strobes decode from the state register; only inst_latch_en sees ifu_ack.
module exu_seq_ctrl
  import exu_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ifu_req,
  input  logic                      ifu_ack,
  input  logic [INST_NUM_WIDTH-1:0] inst_num,
  input  logic                      inst_illegal,
  input  logic [ISA_WIDTH-1:0]      alu_result,
  output logic                      inst_latch_en,
  output logic                      alu_latch_en,
  output logic                      mem_ren,
  output logic                      mem_wen,
  input  logic                      mem_ack,
  output logic                      rf_wen,
  output logic                      pc_wen,
  output logic [PC_SEL_WIDTH-1:0]   pc_sel,
  output logic                      halt,
  output logic                      err,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      instret_cnt
);

  seq_state_t state, state_nxt;
  logic taken;
  logic wait_st, ack, expired;
  logic is_lw, is_sw, is_br, is_jal, is_jalr, is_ebreak;
  logic alu_unused;

  assign alu_unused = ^alu_result[ISA_WIDTH-1:1];

  assign is_lw = (inst_num == INST_LW);
  assign is_sw = (inst_num == INST_SW);
  assign is_br = is_branch(inst_num);
  assign is_jal = (inst_num == INST_JAL);
  assign is_jalr = (inst_num == INST_JALR);
  assign is_ebreak = (inst_num == INST_EBREAK);

  assign wait_st = (state == SEQ_FETCH) ||
                   (state == SEQ_MEM_RD) ||
                   (state == SEQ_MEM_WR);
  assign ack = ((state == SEQ_FETCH) && ifu_ack) ||
               ((state == SEQ_MEM_RD) && mem_ack) ||
               ((state == SEQ_MEM_WR) && mem_ack);

  seq_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wait_st),
    .tick   (wait_st && !ack),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE: state_nxt = SEQ_FETCH;
      SEQ_FETCH: begin
        if (ifu_ack) state_nxt = SEQ_DECODE;
        else if (expired) state_nxt = SEQ_ERR;
      end
      SEQ_DECODE: begin
        if (inst_illegal) state_nxt = SEQ_ERR;
        else if (is_ebreak) state_nxt = SEQ_HALT;
        else state_nxt = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (is_lw) state_nxt = SEQ_MEM_RD;
        else if (is_sw) state_nxt = SEQ_MEM_WR;
        else state_nxt = SEQ_WB;
      end
      SEQ_MEM_RD, SEQ_MEM_WR: begin
        if (mem_ack) state_nxt = SEQ_WB;
        else if (expired) state_nxt = SEQ_ERR;
      end
      SEQ_WB: state_nxt = SEQ_FETCH;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEQ_IDLE;
      taken <= 1'b0;
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != SEQ_HALT && state != SEQ_ERR)
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      // ebreak retires on its way into HALT
      if (state == SEQ_WB ||
          (state == SEQ_DECODE && state_nxt == SEQ_HALT))
        instret_cnt <= instret_cnt + CNT_WIDTH'(1);
      if (state == SEQ_EXEC)
        taken <= is_br & alu_result[0];
    end
  end

  assign ifu_req = (state == SEQ_FETCH);
  assign inst_latch_en = (state == SEQ_FETCH) && ifu_ack;
  assign alu_latch_en = (state == SEQ_EXEC);
  assign mem_ren = (state == SEQ_MEM_RD);
  assign mem_wen = (state == SEQ_MEM_WR);
  assign pc_wen = (state == SEQ_WB);
  assign rf_wen = (state == SEQ_WB) && !(is_sw || is_br);
  assign halt = (state == SEQ_HALT) || (state == SEQ_ERR);
  assign err = (state == SEQ_ERR);

  always_comb begin
    pc_sel = PC_SNPC;
    if (state == SEQ_WB) begin
      unique case (1'b1)
        is_jalr: pc_sel = PC_JALR;
        is_jal, (is_br && taken): pc_sel = PC_IMM;
        default: pc_sel = PC_SNPC;
      endcase
    end
  end

endmodule
